// File: rtl/fft_feeder_if.sv
// Bundles the sample, butterfly and spectrum handshakes of fft_feeder.
// slave is the feeder side; master is the environment side.
interface fft_feeder_if #(
    parameter int N = 16
);
    logic         i_valid;
    logic [N-1:0] i_re;
    logic [N-1:0] i_im;
    logic         o_ready;
    logic [N-1:0] o_in0_re;
    logic [N-1:0] o_in0_im;
    logic [N-1:0] o_in1_re;
    logic [N-1:0] o_in1_im;
    logic [N-1:0] o_twiddle_re;
    logic [N-1:0] o_twiddle_im;
    logic         i_bf_done;
    logic [N-1:0] i_out0_re;
    logic [N-1:0] i_out0_im;
    logic [N-1:0] i_out1_re;
    logic [N-1:0] i_out1_im;
    logic         o_valid;
    logic [N-1:0] o_re;
    logic [N-1:0] o_im;
    logic         i_ready;
    logic         o_busy;

    modport slave (
        input  i_valid, i_re, i_im,
        output o_ready,
        output o_in0_re, o_in0_im, o_in1_re, o_in1_im,
        output o_twiddle_re, o_twiddle_im,
        input  i_bf_done,
        input  i_out0_re, i_out0_im, i_out1_re, i_out1_im,
        output o_valid, o_re, o_im,
        input  i_ready,
        output o_busy
    );

    modport master (
        output i_valid, i_re, i_im,
        input  o_ready,
        input  o_in0_re, o_in0_im, o_in1_re, o_in1_im,
        input  o_twiddle_re, o_twiddle_im,
        output i_bf_done,
        output i_out0_re, i_out0_im, i_out1_re, i_out1_im,
        input  o_valid, o_re, o_im,
        output i_ready,
        input  o_busy
    );
endinterface

// File: rtl/fft_feeder.sv
// 16-point radix-2 DIT sequencer: loads bit-reversed, feeds an external butterfly, streams bins.
// Define FFT_FEEDER_SCALE_EN to halve every butterfly result on write-back (1/16 overall).
module fft_feeder #(
    parameter int N        = 16,
    parameter int Q        = 8,
    parameter int BF_EDGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    fft_feeder_if.slave bus
);
    localparam int EW     = (BF_EDGES > 1) ? $clog2(BF_EDGES + 1) : 1;
    localparam int TW_SHL = (Q >= 8) ? Q - 8 : 0;
    localparam int TW_SHR = (Q < 8) ? 8 - Q : 0;

    typedef enum logic [2:0] {S_LOAD, S_ISSUE, S_WAIT, S_WRITE, S_OUTPUT} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      stage_reg, stage_next;
    logic [2:0]      bfly_reg, bfly_next;
    logic [3:0]      bin_reg, bin_next;
    logic [3:0]      load_cnt_reg, load_cnt_next;
    logic [EW-1:0]   edge_cnt_reg, edge_cnt_next;
    logic            bf_done_d_reg;
    logic            o_ready_reg, o_ready_next;
    logic            o_valid_reg, o_valid_next;
    logic [N-1:0]    o_re_reg, o_re_next, o_im_reg, o_im_next;
    logic [N-1:0]    in0_re_reg, in0_re_next, in0_im_reg, in0_im_next;
    logic [N-1:0]    in1_re_reg, in1_re_next, in1_im_reg, in1_im_next;
    logic [N-1:0]    tw_re_reg, tw_re_next, tw_im_reg, tw_im_next;

    logic [N-1:0]    mem_re [16];
    logic [N-1:0]    mem_im [16];

    logic [3:0]      load_addr, addr_a, addr_b;
    logic [2:0]      tw_k;
    logic            load_we, bf_we, bf_edge;
    logic [N-1:0]    wr0_re, wr0_im, wr1_re, wr1_im;

    // Twiddle table is held at Q=8 and rescaled for other fractional widths.
    function automatic logic [N-1:0] tw_re_f(input logic [2:0] k);
        logic signed [31:0] v;
        v = 32'sd0;
        case (k)
            3'd0: v = 32'sd256;
            3'd1: v = 32'sd237;
            3'd2: v = 32'sd181;
            3'd3: v = 32'sd98;
            3'd4: v = 32'sd0;
            3'd5: v = -32'sd98;
            3'd6: v = -32'sd181;
            default: v = -32'sd237;
        endcase
        return N'((v <<< TW_SHL) >>> TW_SHR);
    endfunction

    function automatic logic [N-1:0] tw_im_f(input logic [2:0] k);
        logic signed [31:0] v;
        v = 32'sd0;
        case (k)
            3'd0: v = 32'sd0;
            3'd1: v = -32'sd98;
            3'd2: v = -32'sd181;
            3'd3: v = -32'sd237;
            3'd4: v = -32'sd256;
            3'd5: v = -32'sd237;
            3'd6: v = -32'sd181;
            default: v = -32'sd98;
        endcase
        return N'((v <<< TW_SHL) >>> TW_SHR);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bitrev
            assign load_addr[gi] = load_cnt_reg[3-gi];
        end
    endgenerate

    // Bit s of addr_a is always zero, so the partner index is a simple OR.
    always_comb begin
        addr_a = 4'd0;
        tw_k   = 3'd0;
        case (stage_reg)
            2'd0: begin addr_a = {bfly_reg, 1'b0};                       tw_k = 3'd0;                   end
            2'd1: begin addr_a = {bfly_reg[2:1], 1'b0, bfly_reg[0]};     tw_k = {bfly_reg[0], 2'b00};   end
            2'd2: begin addr_a = {bfly_reg[2], 1'b0, bfly_reg[1:0]};     tw_k = {bfly_reg[1:0], 1'b0};  end
            default: begin addr_a = {1'b0, bfly_reg};                     tw_k = bfly_reg;               end
        endcase
    end
    assign addr_b  = addr_a | (4'd1 << stage_reg);
    assign bf_edge = bus.i_bf_done & ~bf_done_d_reg;

`ifdef FFT_FEEDER_SCALE_EN
    assign wr0_re = N'($signed(bus.i_out0_re) >>> 1);
    assign wr0_im = N'($signed(bus.i_out0_im) >>> 1);
    assign wr1_re = N'($signed(bus.i_out1_re) >>> 1);
    assign wr1_im = N'($signed(bus.i_out1_im) >>> 1);
`else
    assign wr0_re = bus.i_out0_re;
    assign wr0_im = bus.i_out0_im;
    assign wr1_re = bus.i_out1_re;
    assign wr1_im = bus.i_out1_im;
`endif

    always_comb begin
        state_next    = state_reg;
        stage_next    = stage_reg;
        bfly_next     = bfly_reg;
        bin_next      = bin_reg;
        load_cnt_next = load_cnt_reg;
        edge_cnt_next = edge_cnt_reg;
        o_valid_next  = o_valid_reg;
        o_re_next     = o_re_reg;
        o_im_next     = o_im_reg;
        in0_re_next   = in0_re_reg;
        in0_im_next   = in0_im_reg;
        in1_re_next   = in1_re_reg;
        in1_im_next   = in1_im_reg;
        tw_re_next    = tw_re_reg;
        tw_im_next    = tw_im_reg;
        load_we       = 1'b0;
        bf_we         = 1'b0;
        case (state_reg)
            S_LOAD: begin
                if (bus.i_valid && o_ready_reg) begin
                    load_we       = 1'b1;
                    load_cnt_next = load_cnt_reg + 4'd1;
                    if (load_cnt_reg == 4'd15) begin
                        state_next = S_ISSUE;
                        stage_next = 2'd0;
                        bfly_next  = 3'd0;
                    end
                end
            end
            S_ISSUE: begin
                in0_re_next   = mem_re[addr_a];
                in0_im_next   = mem_im[addr_a];
                in1_re_next   = mem_re[addr_b];
                in1_im_next   = mem_im[addr_b];
                tw_re_next    = tw_re_f(tw_k);
                tw_im_next    = tw_im_f(tw_k);
                edge_cnt_next = '0;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                if (bf_edge) begin
                    if (edge_cnt_reg == EW'(BF_EDGES - 1)) state_next = S_WRITE;
                    else edge_cnt_next = edge_cnt_reg + EW'(1);
                end
            end
            S_WRITE: begin
                bf_we = 1'b1;
                if (bfly_reg != 3'd7) begin
                    bfly_next  = bfly_reg + 3'd1;
                    state_next = S_ISSUE;
                end else if (stage_reg != 2'd3) begin
                    stage_next = stage_reg + 2'd1;
                    bfly_next  = 3'd0;
                    state_next = S_ISSUE;
                end else begin
                    bin_next   = 4'd0;
                    state_next = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                // First cycle fetches bin 0; afterwards each handshake fetches the next bin.
                if (!o_valid_reg) begin
                    o_valid_next = 1'b1;
                    o_re_next    = mem_re[bin_reg];
                    o_im_next    = mem_im[bin_reg];
                end else if (bus.i_ready) begin
                    if (bin_reg == 4'd15) begin
                        o_valid_next = 1'b0;
                        bin_next     = 4'd0;
                        state_next   = S_LOAD;
                    end else begin
                        bin_next  = bin_reg + 4'd1;
                        o_re_next = mem_re[bin_reg + 4'd1];
                        o_im_next = mem_im[bin_reg + 4'd1];
                    end
                end
            end
            default: state_next = S_LOAD;
        endcase
        o_ready_next = (state_next == S_LOAD);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= S_LOAD;
            stage_reg     <= '0;
            bfly_reg      <= '0;
            bin_reg       <= '0;
            load_cnt_reg  <= '0;
            edge_cnt_reg  <= '0;
            bf_done_d_reg <= 1'b0;
            o_ready_reg   <= 1'b0;
            o_valid_reg   <= 1'b0;
            o_re_reg      <= '0;
            o_im_reg      <= '0;
            in0_re_reg    <= '0;
            in0_im_reg    <= '0;
            in1_re_reg    <= '0;
            in1_im_reg    <= '0;
            tw_re_reg     <= '0;
            tw_im_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            stage_reg     <= stage_next;
            bfly_reg      <= bfly_next;
            bin_reg       <= bin_next;
            load_cnt_reg  <= load_cnt_next;
            edge_cnt_reg  <= edge_cnt_next;
            bf_done_d_reg <= bus.i_bf_done;
            o_ready_reg   <= o_ready_next;
            o_valid_reg   <= o_valid_next;
            o_re_reg      <= o_re_next;
            o_im_reg      <= o_im_next;
            in0_re_reg    <= in0_re_next;
            in0_im_reg    <= in0_im_next;
            in1_re_reg    <= in1_re_next;
            in1_im_reg    <= in1_im_next;
            tw_re_reg     <= tw_re_next;
            tw_im_reg     <= tw_im_next;
        end
    end

    // Sample memory keeps its contents across reset; a new frame always reloads all 16 words.
    always_ff @(posedge i_clk) begin
        if (load_we) begin
            mem_re[load_addr] <= bus.i_re;
            mem_im[load_addr] <= bus.i_im;
        end
        if (bf_we) begin
            mem_re[addr_a] <= wr0_re;
            mem_im[addr_a] <= wr0_im;
            mem_re[addr_b] <= wr1_re;
            mem_im[addr_b] <= wr1_im;
        end
    end

    assign bus.o_ready      = o_ready_reg;
    assign bus.o_valid      = o_valid_reg;
    assign bus.o_re         = o_re_reg;
    assign bus.o_im         = o_im_reg;
    assign bus.o_in0_re     = in0_re_reg;
    assign bus.o_in0_im     = in0_im_reg;
    assign bus.o_in1_re     = in1_re_reg;
    assign bus.o_in1_im     = in1_im_reg;
    assign bus.o_twiddle_re = tw_re_reg;
    assign bus.o_twiddle_im = tw_im_reg;
    assign bus.o_busy       = (state_reg != S_LOAD);
endmodule

// File: tb/tb_fft_feeder.sv
// Directed bench for fft_feeder: acts as upstream source, butterfly unit and downstream sink.
// Expected spectra follow FFT_FEEDER_SCALE_EN when the bench is built with it.
module tb_fft_feeder;
    localparam int N        = 16;
    localparam int Q        = 8;
    localparam int BF_EDGES = 2;
`ifdef FFT_FEEDER_SCALE_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_feeder_if #(.N(N)) bus ();

    fft_feeder #(.N(N), .Q(Q), .BF_EDGES(BF_EDGES)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [N-1:0] x_re [16];
    logic [N-1:0] x_im [16];
    logic [N-1:0] e_re [16];
    logic [N-1:0] e_im [16];
    logic [15:0]  tw_r_t [8] = '{16'h0100, 16'h00ED, 16'h00B5, 16'h0062,
                                 16'h0000, 16'hFF9E, 16'hFF4B, 16'hFF13};
    logic [15:0]  tw_i_t [8] = '{16'h0000, 16'hFF9E, 16'hFF4B, 16'hFF13,
                                 16'hFF00, 16'hFF13, 16'hFF4B, 16'hFF9E};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic load_frame();
        for (int n = 0; n < 16; n++) begin
            int t;
            bus.i_valid = 1'b1;
            bus.i_re    = x_re[n];
            bus.i_im    = x_im[n];
            t = 0;
            while (!bus.o_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            check("load_ready", bus.o_ready, 1);
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
    endtask

    // Plays the butterfly unit; garbage on the sample input must be ignored meanwhile.
    task automatic run_bfly(input bit chk_ops, input int abort_s, output bit aborted);
        aborted     = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_re    = 16'h7777;
        bus.i_im    = 16'h5555;
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 8; j++) begin
                logic signed [N-1:0] a_r, a_i, b_r, b_i, w_r, w_i;
                int p_r, p_i;
                @(posedge clk); #1;
                if (s == 0 && j == 0) begin
                    check("busy_wait", bus.o_busy, 1);
                    check("s0j0_in0_re", bus.o_in0_re, x_re[0]);
                    check("s0j0_in1_re", bus.o_in1_re, x_re[8]);
                    check("s0j0_tw_re", bus.o_twiddle_re, 16'h0100);
                end
                if (s == 3 && j == 2) begin
                    check("s3j2_tw_re", bus.o_twiddle_re, 16'h00B5);
                    check("s3j2_tw_im", bus.o_twiddle_im, 16'hFF4B);
                    if (chk_ops) begin
                        check("s3j2_in0_re", bus.o_in0_re, 16'(256 >>> (3 * SH)));
                        check("s3j2_in0_im", bus.o_in0_im, 16'h0000);
                        check("s3j2_in1_re", bus.o_in1_re, 16'h0000);
                    end
                end
                if (s == abort_s && j == 0) begin
                    rst = 1'b1;
                    #2;
                    check("rst_async_in0", bus.o_in0_re, 16'h0000);
                    check("rst_async_tw", bus.o_twiddle_re, 16'h0000);
                    check("rst_async_busy", bus.o_busy, 0);
                    check("rst_async_ready", bus.o_ready, 0);
                    @(posedge clk); #1;
                    rst = 1'b0;
                    @(posedge clk); #1;
                    check("rst_rel_ready", bus.o_ready, 1);
                    check("rst_rel_valid", bus.o_valid, 0);
                    check("rst_rel_busy", bus.o_busy, 0);
                    check("rst_rel_in0", bus.o_in0_re, 16'h0000);
                    bus.i_valid = 1'b0;
                    aborted = 1'b1;
                    return;
                end
                a_r = $signed(bus.o_in0_re);  a_i = $signed(bus.o_in0_im);
                b_r = $signed(bus.o_in1_re);  b_i = $signed(bus.o_in1_im);
                w_r = $signed(bus.o_twiddle_re); w_i = $signed(bus.o_twiddle_im);
                p_r = (int'(b_r) * int'(w_r) - int'(b_i) * int'(w_i)) >>> Q;
                p_i = (int'(b_r) * int'(w_i) + int'(b_i) * int'(w_r)) >>> Q;
                bus.i_out0_re = N'(int'(a_r) + p_r);
                bus.i_out0_im = N'(int'(a_i) + p_i);
                bus.i_out1_re = N'(int'(a_r) - p_r);
                bus.i_out1_im = N'(int'(a_i) - p_i);
                repeat (BF_EDGES) begin
                    bus.i_bf_done = 1'b1;
                    @(posedge clk); #1;
                    bus.i_bf_done = 1'b0;
                    @(posedge clk); #1;
                end
            end
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic collect_output(input bit bp);
        int t;
        bus.i_ready = 1'b1;
        t = 0;
        while (!bus.o_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        for (int m = 0; m < 16; m++) begin
            check("out_valid", bus.o_valid, 1);
            check($sformatf("bin%0d_re", m), bus.o_re, e_re[m]);
            check($sformatf("bin%0d_im", m), bus.o_im, e_im[m]);
            $display("bin %2d: re=%h im=%h", m, bus.o_re, bus.o_im);
            if (bp && m == 3) begin
                bus.i_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    check("bp_valid", bus.o_valid, 1);
                    check("bp_hold_re", bus.o_re, e_re[3]);
                end
                bus.i_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("end_valid_low", bus.o_valid, 0);
        check("end_ready_high", bus.o_ready, 1);
        bus.i_ready = 1'b0;
    endtask

    task automatic set_impulse();
        for (int n = 0; n < 16; n++) begin
            x_re[n] = (n == 0) ? 16'h0100 : 16'h0000;
            x_im[n] = 16'h0000;
            e_re[n] = 16'(256 >>> (4 * SH));
            e_im[n] = 16'h0000;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab;
        int bm;
        bus.i_valid   = 1'b0;
        bus.i_re      = '0;
        bus.i_im      = '0;
        bus.i_bf_done = 1'b0;
        bus.i_ready   = 1'b0;
        bus.i_out0_re = '0; bus.i_out0_im = '0;
        bus.i_out1_re = '0; bus.i_out1_im = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.o_ready, 0);
        check("rst_valid", bus.o_valid, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_in0", bus.o_in0_re, 16'h0000);
        check("rst_tw", bus.o_twiddle_re, 16'h0000);
        check("rst_out", bus.o_re, 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_first_clk", bus.o_ready, 1);

        // DC frame
        for (int n = 0; n < 16; n++) begin
            x_re[n] = 16'h0010;
            x_im[n] = 16'h0000;
            e_re[n] = (n == 0) ? 16'(256 >>> (4 * SH)) : 16'h0000;
            e_im[n] = 16'h0000;
        end
        load_frame();
        run_bfly(1'b0, -1, ab);
        collect_output(1'b0);

        // Impulse with output backpressure at bin 3
        set_impulse();
        load_frame();
        run_bfly(1'b1, -1, ab);
        collect_output(1'b1);

        // Impulse abandoned by reset during stage 2, then a clean impulse frame
        load_frame();
        run_bfly(1'b1, 2, ab);
        check("abort_taken", ab, 1);
        set_impulse();
        load_frame();
        run_bfly(1'b1, -1, ab);
        collect_output(1'b0);

        // Delayed impulse: bins are W16^k, exercising every twiddle and its negation
        bm = 256 >>> (3 * SH);
        for (int n = 0; n < 16; n++) begin
            x_re[n] = (n == 1) ? 16'h0100 : 16'h0000;
            x_im[n] = 16'h0000;
        end
        for (int k = 0; k < 8; k++) begin
            int pr, pi;
            pr = (bm * int'($signed(tw_r_t[k]))) >>> Q;
            pi = (bm * int'($signed(tw_i_t[k]))) >>> Q;
            e_re[k]     = N'(pr >>> SH);
            e_im[k]     = N'(pi >>> SH);
            e_re[k + 8] = N'((-pr) >>> SH);
            e_im[k + 8] = N'((-pi) >>> SH);
        end
        load_frame();
        run_bfly(1'b0, -1, ab);
        collect_output(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/fft_feeder.md
FFT_FEEDER -- requirements
Module: fft_feeder

Interface
REQ-001 Parameter N, default 16: sample and twiddle word width, signed two's complement.
REQ-002 Parameter Q, default 8: fractional bits; 1.0 = 2^Q.
REQ-003 Parameter BF_EDGES, default 2: number of i_bf_done rising edges awaited per butterfly.
REQ-004 i_clk  in  1: single clock; all state on rising edge.
REQ-005 i_rst  in  1: reset, asynchronous, active-high.
REQ-006 i_valid, i_re[N], i_im[N]  in: input sample stream, natural order.
REQ-007 o_ready  out  1: feeder accepts an input sample.
REQ-008 o_in0_re, o_in0_im, o_in1_re, o_in1_im  out  N each: butterfly operands.
REQ-009 o_twiddle_re, o_twiddle_im  out  N each: twiddle W16^k.
REQ-010 i_bf_done  in  1: butterfly completion level, sampled on i_clk.
REQ-011 i_out0_re, i_out0_im, i_out1_re, i_out1_im  in  N each: butterfly results.
REQ-012 o_valid, o_re[N], o_im[N]  out: spectrum stream, bins 0..15 in order.
REQ-013 i_ready  in  1: downstream accepts an output sample.
REQ-014 o_busy  out  1: high in every state except LOAD.

Function
REQ-015 Memory: 16 complex words. Load writes sample n to address bitrev4(n).
REQ-016 FSM states: LOAD, ISSUE, WAIT, WRITE, OUTPUT.
REQ-017 LOAD: o_ready=1. A transfer occurs on i_valid&o_ready. After the 16th transfer the FSM goes to ISSUE, with stage s=0 and butterfly j=0.
REQ-018 Stage s (0..3), butterfly j (0..7): span=2^s; a = (j/span)*2*span + (j mod span); b = a+span; k = (j mod span)*(8>>s).
REQ-019 ISSUE: register mem[a] onto o_in0, mem[b] onto o_in1 and ROM[k] onto o_twiddle in one cycle, then go to WAIT. Operand outputs hold until the next ISSUE.
REQ-020 Twiddle ROM, Q=8 values:
- k0 = (0x0100, 0x0000)
- k1 = (0x00ED, 0xFF9E)
- k2 = (0x00B5, 0xFF4B)
- k3 = (0x0062, 0xFF13)
- k4 = (0x0000, 0xFF00)
- k5 = (0xFF9E, 0xFF13)
- k6 = (0xFF4B, 0xFF4B)
- k7 = (0xFF13, 0xFF9E)
REQ-021 Twiddle encoding: re = round(cos(2*pi*k/16)*2^Q), im = -round(sin(2*pi*k/16)*2^Q).
REQ-022 WAIT: detect i_bf_done 0->1 using a one-cycle-delayed copy of i_bf_done.
- On the BF_EDGES-th edge counted since ISSUE, go to WRITE.
- Edges before ISSUE are not counted.
REQ-023 WRITE: capture i_out0 into mem[a] and i_out1 into mem[b] in one cycle.
- If j<7: j+=1 and go to ISSUE.
- Else if s<3: s+=1, j=0, go to ISSUE.
- Else: go to OUTPUT.
REQ-024 OUTPUT: present mem[m] for m=0..15 with o_valid=1. m advances on o_valid&i_ready. After the bin 15 transfer, o_valid=0 and the FSM goes to LOAD.
REQ-025 Backpressure: while i_ready=0, o_valid, o_re and o_im are held stable.
REQ-026 i_valid outside LOAD is ignored and no sample is lost. Upstream holds data because o_ready=0.
REQ-027 i_bf_done edges in LOAD or OUTPUT are ignored.
REQ-028 Results are written truncated to N bits with no saturation.

Reset
REQ-029 On i_rst, all of the following are cleared:
- o_ready=0, o_valid=0, o_busy=0.
- All operand, twiddle and output data = 0.
- FSM = LOAD; s, j, m, load count and edge count = 0; the delayed copy of i_bf_done = 0.
REQ-030 Memory contents are not reset.
REQ-031 o_ready rises on the first clock after i_rst deasserts.
REQ-032 Reset mid-operation abandons the frame. The next frame needs a full 16-sample load.

Configuration
REQ-033 Macro FFT_FEEDER_SCALE_EN:
- Defined: WRITE stores each result arithmetically shifted right by 1, giving a total output scaling of 1/16.
- Undefined: results are stored unmodified.

Verification
REQ-034 Impulse, scale off: load x[0]=(0x0100,0), x[1..15]=0 -> all 16 bins = (0x0100, 0x0000).
REQ-035 DC, scale off: all x=(0x0010,0) -> bin0=(0x0100,0), bins 1..15=(0,0).
REQ-036 Scale on, same impulse: all bins = (0x0010, 0x0000).
REQ-037 Twiddle check: at stage 3, j=2 -> o_twiddle=(0x00B5, 0xFF4B), and o_in0/o_in1 show mem[2]/mem[10].
REQ-038 Output backpressure: hold i_ready=0 for 5 cycles at bin 3 -> bin 3 data is held stable, then bins 3..15 follow with none lost or duplicated.
REQ-039 Reset mid-frame: assert i_rst during stage 2 WAIT -> outputs are zero and o_ready=1 one cycle after release; the next impulse frame gives the REQ-034 result.
